// File: rtl/sipo_frame_rx.sv
// MSB-first serial-to-parallel frame receiver with a valid/ready output word.
// Define SIPO_PARITY_EN to add a trailing even-parity bit and parity_err.
module sipo_frame_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial,
  input  logic             frame_start,
  input  logic             out_ready,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             busy,
`ifdef SIPO_PARITY_EN
  output logic             parity_err,
`endif
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
`ifdef SIPO_PARITY_EN
    PARITY,
`endif
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shift, shift_n;
  logic [CW-1:0]    count, count_n;
  logic [WIDTH-1:0] pout_n, word_n, next_word;
  logic             valid_n, ovr_n, xfer;
`ifdef SIPO_PARITY_EN
  logic             perr_n, perr_x;
`endif

  assign next_word = {shift[WIDTH-2:0], serial};
  assign busy      = (state != IDLE);

  always_comb begin
    state_n = state;
    shift_n = shift;
    count_n = count;
    xfer    = 1'b0;
    word_n  = shift;
`ifdef SIPO_PARITY_EN
    perr_x  = 1'b0;
`endif
    if (frame_start) begin
      // A new MSB always wins, even over a frame in flight.
      shift_n = WIDTH'(serial);
      count_n = CW'(1);
      state_n = SHIFT;
    end else begin
      case (state)
        SHIFT: begin
          shift_n = next_word;
          count_n = count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            count_n = '0;
`ifdef SIPO_PARITY_EN
            state_n = PARITY;
`else
            xfer    = 1'b1;
            word_n  = next_word;
            state_n = IDLE;
`endif
          end
        end
`ifdef SIPO_PARITY_EN
        PARITY: begin
          xfer    = 1'b1;
          word_n  = shift;
          perr_x  = ^{shift, serial};
          state_n = IDLE;
        end
`endif
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    pout_n  = parallel_out;
    valid_n = out_valid;
    ovr_n   = overrun;
`ifdef SIPO_PARITY_EN
    perr_n  = parity_err;
`endif
    if (xfer) begin
      if (!out_valid || out_ready) begin
        pout_n  = word_n;
        valid_n = 1'b1;
`ifdef SIPO_PARITY_EN
        perr_n  = perr_x;
`endif
      end else begin
        ovr_n = 1'b1;
      end
    end else if (out_valid && out_ready) begin
      valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      shift        <= '0;
      count        <= '0;
      parallel_out <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
`ifdef SIPO_PARITY_EN
      parity_err   <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      shift        <= shift_n;
      count        <= count_n;
      parallel_out <= pout_n;
      out_valid    <= valid_n;
      overrun      <= ovr_n;
`ifdef SIPO_PARITY_EN
      parity_err   <= perr_n;
`endif
    end
  end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Bench for sipo_frame_rx: directed scenarios plus random traffic
// compared each cycle against a bit-queue reference model.
module tb_sipo_frame_rx;

  localparam int W = 4;
`ifdef SIPO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         serial = 1'b0;
  logic         frame_start = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] parallel_out;
  logic         out_valid, busy, overrun;
`ifdef SIPO_PARITY_EN
  logic         parity_err;
`endif

  int total = 0;
  int bad = 0;

  // reference model state
  bit           m_active;
  bit           m_bits[$];
  logic [W-1:0] m_word;
  bit           m_valid, m_ovr, m_perr;

  sipo_frame_rx #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .serial       (serial),
    .frame_start  (frame_start),
    .out_ready    (out_ready),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .busy         (busy),
`ifdef SIPO_PARITY_EN
    .parity_err   (parity_err),
`endif
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_active = 0;
    m_bits.delete();
    m_word = '0;
    m_valid = 0;
    m_ovr = 0;
    m_perr = 0;
  endfunction

  function automatic void m_step(bit fs, bit ser, bit rdy);
    bit done = 0;
    logic [W-1:0] w = '0;
    bit p = 0;
    if (fs) begin
      m_bits.delete();
      m_bits.push_back(ser);
      m_active = 1;
    end else if (m_active) begin
      m_bits.push_back(ser);
      if (m_bits.size() == FL) begin
        for (int i = 0; i < W; i++) w = (w << 1) | W'(m_bits[i]);
        foreach (m_bits[i]) p ^= m_bits[i];
        m_active = 0;
        m_bits.delete();
        done = 1;
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_word = w;
        m_valid = 1;
        m_perr = p;
      end else begin
        m_ovr = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endfunction

  task automatic compare_all();
    chk("valid", 32'(out_valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_active));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("word", 32'(parallel_out), 32'(m_word));
`ifdef SIPO_PARITY_EN
    chk("perr", 32'(parity_err), 32'(m_perr));
`endif
  endtask

  task automatic cycle(input bit fs, input bit ser, input bit rdy);
    frame_start = fs;
    serial = ser;
    out_ready = rdy;
    @(posedge clk);
    m_step(fs, ser, rdy);
    #1;
    compare_all();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    frame_start = 1'b0;
    m_reset();
    #1;
    compare_all();
    for (int i = 0; i < n; i++) begin
      serial = ~serial;
      @(posedge clk);
      #1;
      compare_all();
    end
    rst = 1'b1;
  endtask

  task automatic send_frame(input logic [W-1:0] word, input bit par,
                            input bit rm, input bit rl);
    for (int i = 0; i < FL; i++)
      cycle(i == 0, (i < W) ? word[W-1-i] : par, (i == FL - 1) ? rl : rm);
  endtask

  initial begin
    m_reset();
    // reset then idle
    do_reset(2);
    chk("rst_word", 32'(parallel_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    repeat (3) cycle(0, $urandom_range(0, 1), 1);

    // single frame with ready held high
    send_frame(4'b1011, ^4'b1011, 1, 1);
    chk("single_word", 32'(parallel_out), 32'hb);
    chk("single_valid", 32'(out_valid), 32'h1);
    cycle(0, 0, 1);
    chk("single_drop", 32'(out_valid), 32'h0);

    // backpressure and overrun
    send_frame(4'b1100, ^4'b1100, 0, 0);
    send_frame(4'b0011, ^4'b0011, 0, 0);
    chk("ovr_word", 32'(parallel_out), 32'hc);
    chk("ovr_flag", 32'(overrun), 32'h1);
    cycle(0, 0, 1);
    chk("ovr_consume", 32'(out_valid), 32'h0);
    do_reset(1);

    // consume in the same cycle a new word lands
    send_frame(4'b0101, ^4'b0101, 0, 0);
    send_frame(4'b1110, ^4'b1110, 0, 1);
    chk("simul_valid", 32'(out_valid), 32'h1);
    chk("simul_word", 32'(parallel_out), 32'he);
    chk("simul_ovr", 32'(overrun), 32'h0);
    cycle(0, 0, 1);

    // abort and restart
    cycle(1, 1, 0);
    cycle(0, 1, 0);
    send_frame(4'b0110, ^4'b0110, 0, 0);
    chk("abort_word", 32'(parallel_out), 32'h6);
    chk("abort_ovr", 32'(overrun), 32'h0);
    cycle(0, 0, 1);
    chk("abort_single", 32'(out_valid), 32'h0);

    // reset mid-frame, then a frame with a deliberately bad parity bit
    cycle(1, 1, 0);
    cycle(0, 0, 0);
    do_reset(1);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_valid", 32'(out_valid), 32'h0);
    send_frame(4'b1011, 1'b0, 0, 0);
    chk("par_word", 32'(parallel_out), 32'hb);
`ifdef SIPO_PARITY_EN
    chk("par_err", 32'(parity_err), 32'h1);
`endif
    cycle(0, 0, 1);

    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) do_reset(1);
      cycle($urandom_range(0, 5) == 0, $urandom_range(0, 1),
            $urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo_frame_rx.md
Name: sipo_frame_rx

Overview:
- Serial-to-parallel receiver; the downstream stage of the 4-bit PISO serializer, consuming its MSB-first serial stream.
- Rebuilds WIDTH-bit words from `serial`, framed by a `frame_start` strobe aligned to the first (MSB) bit.
- Presents each word on a registered valid/ready output port; a separate shift and holding register let the next frame be received while the previous word is held.

Parameters:
- WIDTH, 4, data bits per frame; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- serial  input  1  serial data, MSB first, one bit per clk.
- frame_start  input  1  high in the cycle `serial` carries the MSB of a frame.
- out_ready  input  1  consumer accepts the word when high with out_valid.
- parallel_out  output  WIDTH  received word; stable while out_valid=1 and out_ready=0.
- out_valid  output  1  parallel_out holds an unconsumed word.
- busy  output  1  frame reception in progress (state != IDLE).
- overrun  output  1  sticky; a completed frame was dropped because the holding register was full.

Behaviour:
- Reset (rst=0, async): state=IDLE; shift register, bit counter and parallel_out=0; out_valid=0; busy=0; overrun=0.
  - A reset mid-frame discards the partial word.
  - A reset while holding discards the held word.
- FSM states: IDLE, SHIFT (and PARITY when SIPO_PARITY_EN is defined).
- IDLE:
  - frame_start=1 at an edge → shift[0]<=serial, count<=1, go to SHIFT.
  - Otherwise `serial` is ignored.
- SHIFT:
  - Each edge: shift<={shift[WIDTH-2:0],serial}, count++.
  - On the edge sampling bit index WIDTH-1 (count==WIDTH-1 before the edge), the frame completes.
  - Without parity: transfer, then go to IDLE.
- Transfer at frame completion:
  - If out_valid=0, or out_valid=1 with out_ready=1 in that cycle: parallel_out<={shift[WIDTH-2:0],serial}, out_valid<=1.
  - Otherwise: word dropped, parallel_out unchanged, overrun<=1.
- Latency: frame_start sampled at edge N → out_valid high after edge N+WIDTH-1 (WIDTH=4: 3 edges after the MSB edge).
- Handshake:
  - out_valid && out_ready at an edge with no simultaneous transfer → out_valid<=0; parallel_out holds its value.
  - Simultaneous consume and transfer → out_valid stays 1 with the new word.
  - out_valid never drops without out_ready.
- frame_start=1 while in SHIFT/PARITY: abort the current frame without flagging overrun, restart with this bit as MSB (count<=1).
- Back-to-back frames: frame_start may assert in the cycle after completion (state IDLE). A frame_start in the same edge as completion counts as abort-and-restart, so the completing word is lost; producers must not do this.
- busy=1 exactly while state != IDLE.
- overrun clears only on reset.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - After the last data bit, FSM enters PARITY and samples one extra even-parity bit; the transfer happens at that edge.
  - Latency becomes WIDTH edges.
  - Extra output port parity_err (1 bit, reset 0) is registered with parallel_out: 1 when the XOR of the data bits and the parity bit is 1.
  - parity_err follows the same hold/overrun rules as parallel_out.
- Undefined:
  - No PARITY state and no parity_err port.
  - Frame is exactly WIDTH bits.

Test Plan:
- Reset then idle: rst low 2 cycles, serial toggling, frame_start=0 → out_valid=0, busy=0, overrun=0, parallel_out=0.
- Single frame, WIDTH=4, out_ready=1: frame_start with bits 1,0,1,1 on four consecutive edges → parallel_out=4'b1011, out_valid high for one cycle after the 4th edge.
- Backpressure/overrun: out_ready=0, frames 4'b1100 then 4'b0011 back-to-back → parallel_out stays 4'b1100, overrun=1. Then out_ready=1 → out_valid clears next edge.
- Simultaneous consume and transfer: word 4'b0101 held, out_ready=1 on the completion edge of 4'b1110 → out_valid stays 1, parallel_out=4'b1110, overrun=0.
- Abort/restart: frame_start, bits 1,1, then frame_start with 0,1,1,0 → single word 4'b0110, no overrun.
- Reset mid-frame plus parity (SIPO_PARITY_EN): rst pulse after 2 bits → busy=0, no output. Then frame 1,0,1,1 with parity bit 0 → parallel_out=4'b1011, parity_err=1.
